// File: rtl/counter_pkg.sv
// Shared types, defaults and helpers for the modulo counter family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package counter_pkg;

  localparam int     DEF_WIDTH    = 4;
  localparam longint DEF_MODULUS  = 16;
  localparam int     DEF_PRESCALE = 1;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  typedef enum logic {
    LIM_WRAP = 1'b0,
    LIM_SAT  = 1'b1
  } lim_mode_t;

  // Limit a load value to the legal count range 0..modulus-1.
  // modulus is 33 bits wide so that a full 32-bit range (2**32) is representable.
  function automatic logic [31:0] clamp_load(input logic [31:0] val,
                                             input logic [32:0] modulus);
    logic [32:0] w_top;
    w_top = modulus - 33'd1;
    if ({1'b0, val} > w_top) begin
      return w_top[31:0];
    end
    return val;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable divider: tick is high on every PRESCALE-th enabled cycle.
// Latency: tick is combinational from en and the phase register (same cycle).
// Backpressure: en=0 freezes the phase; clr restarts the period at phase 0.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   en        : advance the phase this cycle
//   clr       : synchronous restart of the phase (wins over en)
//   tick      : en is high and the phase is at its last value
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  if (PRESCALE <= 1) begin : g_bypass
    // Every enabled cycle is a tick; there is no phase to restart, so clr,
    // clk and rstn have no effect here.
    logic w_unused_ins;
    assign w_unused_ins = ^{clk, rstn, clr};
    assign tick = en;
  end else begin : g_div
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_phase;
    logic          w_last;

    assign w_last = (r_phase == LAST);
    assign tick   = en && w_last;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_phase <= '0;
      end else if (clr) begin
        r_phase <= '0;
      end else if (en) begin
        r_phase <= w_last ? '0 : r_phase + PW'(1);
      end
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Synchronous up/down modulo counter with prescale, load, wrap/saturate and terminal-count pulse.
// Latency: count and tc update on the same edge as the qualifying tick or load; outputs are registered.
// Backpressure: en=0 holds count and prescaler phase; load overrides everything and restarts the prescaler.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   en        : count enable (gates prescaler and counter)
//   up        : 1 = increment, 0 = decrement (sampled on ticks only)
//   sat       : 0 = wrap, 1 = saturate at the limits (sampled on ticks only)
//   load      : synchronous parallel load, highest priority
//   load_val  : value taken on load, clamped to MODULUS-1
//   count     : current count
//   tc        : one-cycle pulse on any tick taken at a limit
module mod_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH    = DEF_WIDTH,
  parameter longint MODULUS  = DEF_MODULUS,
  parameter int     PRESCALE = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("mod_counter: WIDTH must be in 1..32");
  end
  if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("mod_counter: MODULUS must be in 2..2**WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("mod_counter: PRESCALE must be at least 1");
  end

  // Top of the count range. Always fits in WIDTH bits, even for MODULUS==2**WIDTH.
  localparam logic [WIDTH-1:0] LIM = WIDTH'(MODULUS - 1);

  logic             w_tick;
  logic             w_at_top;
  logic             w_at_bot;
  logic [WIDTH-1:0] w_load_cl;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_tc_nxt;
  dir_t             w_dir;
  lim_mode_t        w_mode;

  logic [WIDTH-1:0] r_count;
  logic             r_tc;

  // A load restarts the prescale period so the next tick is a full period away.
  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_presc (
    .clk (clk),
    .rstn(rstn),
    .en  (en),
    .clr (load),
    .tick(w_tick)
  );

  assign w_dir     = dir_t'(up);
  assign w_mode    = lim_mode_t'(sat);
  assign w_at_top  = (r_count == LIM);
  assign w_at_bot  = (r_count == '0);
  assign w_load_cl = WIDTH'(clamp_load(32'(load_val), 33'(MODULUS)));

  // Limits are detected explicitly rather than relying on WIDTH-bit overflow,
  // so a non-power-of-two modulus wraps at the same place a full-range one does.
  always_comb begin
    w_count_nxt = r_count;
    w_tc_nxt    = 1'b0;
    if (load) begin
      w_count_nxt = w_load_cl;
    end else if (w_tick) begin
      if (w_dir == DIR_UP) begin
        if (!w_at_top) begin
          w_count_nxt = r_count + WIDTH'(1);
        end else begin
          w_tc_nxt = 1'b1;
          if (w_mode == LIM_WRAP) begin
            w_count_nxt = '0;
          end
        end
      end else begin
        if (!w_at_bot) begin
          w_count_nxt = r_count - WIDTH'(1);
        end else begin
          w_tc_nxt = 1'b1;
          if (w_mode == LIM_WRAP) begin
            w_count_nxt = LIM;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_tc    <= w_tc_nxt;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;

endmodule

// File: tb/tb_mod_counter.sv
// Directed, table-driven bench for mod_counter across three parameter sets.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_mod_counter;

  logic       clk;
  logic       rstn;
  logic       en;
  logic       up;
  logic       sat;
  logic       load;
  logic [7:0] lv8;

  logic [3:0] cnt_a;
  logic       tc_a;
  logic [3:0] cnt_b;
  logic       tc_b;
  logic [7:0] cnt_c;
  logic       tc_c;

  int n_vec;
  int n_bad;

  // A: WIDTH=4, MODULUS=10, PRESCALE=1
  mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_dut_a (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(lv8[3:0]), .count(cnt_a), .tc(tc_a)
  );

  // B: WIDTH=4, MODULUS=10, PRESCALE=3
  mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) u_dut_b (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(lv8[3:0]), .count(cnt_b), .tc(tc_b)
  );

  // C: WIDTH=8, MODULUS=256, PRESCALE=1
  mod_counter #(.WIDTH(8), .MODULUS(256), .PRESCALE(1)) u_dut_c (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(lv8), .count(cnt_c), .tc(tc_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         pre_rst;
    int         dut;
    logic       en;
    logic       up;
    logic       sat;
    logic       load;
    logic [7:0] lv;
    logic [7:0] exp_c;
    logic       exp_tc;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit r, input int d, input logic e, input logic u,
                     input logic s, input logic l, input logic [7:0] v,
                     input logic [7:0] ec, input logic et);
    vec_t x;
    x.pre_rst = r; x.dut = d; x.en = e; x.up = u; x.sat = s; x.load = l;
    x.lv = v; x.exp_c = ec; x.exp_tc = et;
    vt.push_back(x);
  endtask

  task automatic check(input int d, input logic [7:0] ec, input logic et, input string tag);
    logic [7:0] ac;
    logic       at;
    case (d)
      0:       begin ac = {4'd0, cnt_a}; at = tc_a; end
      1:       begin ac = {4'd0, cnt_b}; at = tc_b; end
      default: begin ac = cnt_c;         at = tc_c; end
    endcase
    n_vec++;
    if (ac !== ec || at !== et) begin
      n_bad++;
      $display("FAIL %s: dut%0d got count=%0d tc=%b, expected count=%0d tc=%b",
               tag, d, ac, at, ec, et);
    end
  endtask

  // Called just after a rising edge; reset pulse stays clear of the next edge.
  task automatic do_reset();
    rstn = 1'b0;
    #3;
    rstn = 1'b1;
  endtask

  task automatic drive(input logic e, input logic u, input logic s,
                       input logic l, input logic [7:0] v);
    en = e; up = u; sat = s; load = l; lv8 = v;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rstn  = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);

    // ---------------- table: DUT A (MODULUS=10, PRESCALE=1) ----------------
    for (int i = 1; i <= 9; i++) add(0, 0, 1, 1, 0, 0, 0, 8'(i), 0);
    add(0, 0, 1, 1, 0, 0, 0, 0, 1);   // 9 -> 0 wrap, tc
    add(0, 0, 1, 1, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 1, 0, 0, 0);   // load 0
    add(0, 0, 1, 0, 0, 0, 0, 9, 1);   // down wrap 0 -> 9
    add(0, 0, 1, 0, 0, 0, 0, 8, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0);   // load honoured with en=0
    add(0, 0, 1, 0, 1, 0, 0, 0, 1);   // saturate at 0, tc re-pulses
    add(0, 0, 1, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 1, 1, 0, 0, 1, 0);
    add(0, 0, 0, 1, 1, 1, 14, 9, 0);  // clamp 14 -> 9
    add(0, 0, 1, 1, 1, 0, 0, 9, 1);   // saturate at top
    add(0, 0, 1, 1, 1, 0, 0, 9, 1);
    add(0, 0, 1, 1, 0, 0, 0, 0, 1);   // switch to wrap at top
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);   // en=0 hold
    add(0, 0, 0, 1, 0, 1, 5, 5, 0);
    add(0, 0, 0, 0, 1, 0, 0, 5, 0);
    add(0, 0, 1, 1, 0, 1, 3, 3, 0);   // load beats step
    add(0, 0, 1, 1, 0, 0, 0, 4, 0);

    // ---------------- table: DUT B (PRESCALE=3) ----------------
    add(1, 1, 1, 1, 0, 0, 0, 0, 0);   // enabled cycle 1
    add(0, 1, 1, 1, 0, 0, 0, 0, 0);   // enabled cycle 2
    add(0, 1, 0, 1, 0, 0, 0, 0, 0);   // gap
    add(0, 1, 0, 1, 0, 0, 0, 0, 0);   // gap
    add(0, 1, 1, 1, 0, 0, 0, 1, 0);   // enabled cycle 3 -> first step on 5th clock
    add(0, 1, 1, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 1, 0, 0, 0, 2, 0);
    add(0, 1, 1, 1, 0, 0, 0, 2, 0);
    add(0, 1, 1, 1, 0, 0, 0, 2, 0);
    add(0, 1, 1, 1, 0, 1, 14, 9, 0);  // load on tick edge, clamped, tick dropped
    add(0, 1, 1, 1, 0, 0, 0, 9, 0);
    add(0, 1, 1, 1, 0, 0, 0, 9, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 1);   // next tick three enabled cycles after load
    add(0, 1, 1, 0, 0, 0, 0, 0, 0);   // direction flips mid-period: no effect
    add(0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 1, 0);   // tick samples up=1

    // ---------------- table: DUT C (WIDTH=8, MODULUS=256) ----------------
    add(1, 2, 0, 1, 0, 1, 255, 255, 0);
    add(0, 2, 1, 1, 0, 0, 0, 0, 1);     // 255 -> 0
    add(0, 2, 1, 0, 0, 0, 0, 255, 1);   // 0 -> 255
    add(0, 2, 1, 0, 0, 0, 0, 254, 0);
    add(0, 2, 1, 1, 0, 0, 0, 255, 0);
    add(0, 2, 1, 1, 1, 0, 0, 255, 1);   // saturate at 255
    add(0, 2, 1, 1, 0, 0, 0, 0, 1);

    // Reset state with en=1 held through two edges.
    #22;
    check(0, 8'd0, 1'b0, "reset_a");
    check(1, 8'd0, 1'b0, "reset_b");
    check(2, 8'd0, 1'b0, "reset_c");
    rstn = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].pre_rst) do_reset();
      drive(vt[i].en, vt[i].up, vt[i].sat, vt[i].load, vt[i].lv);
      @(posedge clk);
      #1;
      check(vt[i].dut, vt[i].exp_c, vt[i].exp_tc, $sformatf("vec%0d", i));
    end

    // ---------------- async reset mid-operation (DUT A) ----------------
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    repeat (7) @(posedge clk);
    #1;
    check(0, 8'd7, 1'b0, "run_to_7");
    #2 rstn = 1'b0;
    #1;
    check(0, 8'd0, 1'b0, "async_rst_count");
    check(2, 8'd0, 1'b0, "async_rst_c");
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    check(0, 8'd1, 1'b0, "first_step_after_rst");

    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'd9);
    @(posedge clk);
    #1;
    check(0, 8'd9, 1'b0, "load9");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    @(posedge clk);
    #1;
    check(0, 8'd0, 1'b1, "tc_before_rst");
    #2 rstn = 1'b0;
    #1;
    check(0, 8'd0, 1'b0, "async_rst_tc");
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    check(0, 8'd1, 1'b0, "no_tc_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
